instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Pipeline stage 1 (IF) of the 5-stage RV32I core. Owns the program counter, drives the address of the combinational instruction memory, and captures the returned word with its PC into the IF/ID pipeline register. Honours stall requests from the hazard unit and redirects (taken branch/jump) from EX, inserting bubbles as required.

## Interface
- XLEN, 32: data/address width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hold PC and IF/ID (load-use hazard).
- redirect_i  in  1  taken branch/jump resolved in EX; flush IF/ID.
- redirect_target_i  in  XLEN  new PC when redirect_i=1.
- program_counter  out  XLEN  address to Instruction_Memory; equals the PC register, no combinational path from inputs.
- instruction  in  32  word returned combinationally by Instruction_Memory for program_counter.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- if_id_instr_o  out  32  registered instruction; NOP (32'h0000_0013) when invalid.
- if_id_pc_o  out  XLEN  PC of if_id_instr_o.
- if_id_pc_plus4_o  out  XLEN  if_id_pc_o + 4, registered.
- fetch_misalign_o  out  1  one-cycle pulse: last accepted redirect target had bits[1:0]≠0.

## Operation
- Reset (highest priority): PC←RESET_PC; if_id_valid_o=0, if_id_instr_o=NOP, if_id_pc_o=0, if_id_pc_plus4_o=0, fetch_misalign_o=0; perf counters cleared.
- Per-edge priority after reset: redirect > stall > advance.
- Advance (no stall, no redirect): IF/ID←{valid=1, instruction, PC, PC+4}; PC←PC+4.
- Stall only: PC and all IF/ID fields hold; instruction input ignored.
- Redirect (with or without stall): PC←{redirect_target_i[XLEN-1:2],2'b00}; IF/ID←bubble (valid=0, NOP, pc fields 0). fetch_misalign_o=1 next cycle iff target[1:0]≠0.
- Arithmetic: PC+4 modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 silently.
- Bubble contents are fixed so downstream decode sees a legal addi x0,x0,0.

## Timing
- Fetch latency: 1 cycle; word at PC=N appears on if_id_* the cycle after program_counter=N, if not stalled/redirected.
- First valid output: first edge with reset=0 captures the word at RESET_PC.
- Redirect penalty in this stage: 1 bubble; target word valid in IF/ID two edges after redirect sampled.
- Reset asserted mid-stream: all state discarded at that edge, regardless of stall/redirect.
- Back-to-back redirects: each takes effect; only the last one's target is fetched.
- Stall held N cycles: outputs constant for N cycles, then advance resumes from unchanged PC.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs fetch_count_o (32, +1 per edge loading a valid instruction into IF/ID) and stall_count_o (32, +1 per edge with stall_i=1 and redirect_i=0); both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package riscv_pkg: XLEN, NOP_INSTR (32'h0000_0013), default RESET_PC, if_id_t struct {valid, instr, pc, pc_plus4}.
- One sub-module: if_id_reg — if_id_t register with load/hold/flush controls and reset-to-bubble; top holds PC logic and priority mux.

## Test plan
- Reset then free-run, memory preloaded at 0,4,8,12 -> program_counter 0,4,8,12; if_id_pc_o 0,4,8 one cycle later, valid=1, instructions match memory.
- stall_i high 3 cycles at PC=8 -> program_counter stays 8, if_id_pc_o stays 4 for 3 cycles, then resumes 8,12.
- redirect_i with target 0x40 at PC=12 -> next program_counter 0x40, IF/ID valid=0 with NOP, then if_id_pc_o=0x40 valid.
- Simultaneous stall_i and redirect_i (target 0x20) -> redirect wins: PC=0x20, bubble inserted; target 0x22 -> PC=0x20, fetch_misalign_o pulses once.
- RESET_PC=32'hFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0; reset asserted during stall -> PC=RESET_PC, valid=0.
- With FETCH_PERF_CNT_EN: 5 advances, 2 stalls, 1 redirect -> fetch_count_o=5, stall_count_o=2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, canonical NOP, the default
// reset PC and the IF/ID pipeline register record.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    // A bubble decodes as addi x0,x0,0 so decode never sees an illegal word.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.valid    = 1'b0;
        b.instr    = NOP_INSTR;
        b.pc       = '0;
        b.pc_plus4 = '0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a new entry,
// otherwise the entry holds. Reset also leaves a bubble.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   flush,
    input  if_id_t entry_i,
    output if_id_t entry_o
);

    if_id_t entry_d;
    if_id_t entry_q;

    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d = if_id_bubble();
        end else if (load) begin
            entry_d = entry_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= if_id_bubble();
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: program counter with redirect > stall > advance priority feeding the
// IF/ID register. Define FETCH_PERF_CNT_EN to add fetch/stall performance counters.
module instruction_fetch_stage #(
    parameter int                  XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]     RESET_PC = riscv_pkg::DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic [XLEN-1:0] program_counter,
    input  logic [31:0]     instruction,
    output logic            if_id_valid_o,
    output logic [31:0]     if_id_instr_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc_plus4_o,
    output logic            fetch_misalign_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count_o,
    output logic [31:0]     stall_count_o
`endif
);

    import riscv_pkg::if_id_t;

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign_d;
    logic            misalign_q;
    logic            advance;
    if_id_t          fetch_entry;
    if_id_t          if_id_entry;

    assign pc_plus4 = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
    assign advance  = !redirect_i && !stall_i;

    always_comb begin
        pc_d       = pc_q;
        misalign_d = redirect_i && (redirect_target_i[1:0] != 2'b00);
        if (redirect_i) begin
            pc_d = {redirect_target_i[XLEN-1:2], 2'b00};
        end else if (!stall_i) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        fetch_entry.valid    = 1'b1;
        fetch_entry.instr    = instruction;
        fetch_entry.pc       = pc_q;
        fetch_entry.pc_plus4 = pc_plus4;
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (advance),
        .flush   (redirect_i),
        .entry_i (fetch_entry),
        .entry_o (if_id_entry)
    );

    assign program_counter  = pc_q;
    assign if_id_valid_o    = if_id_entry.valid;
    assign if_id_instr_o    = if_id_entry.instr;
    assign if_id_pc_o       = if_id_entry.pc;
    assign if_id_pc_plus4_o = if_id_entry.pc_plus4;
    assign fetch_misalign_o = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_d;
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (advance && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall_i && !redirect_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, a wrap-around instance,
// perf-counter sequence and randomized traffic against a behavioural model.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_target_i = '0;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic        if_id_valid_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        fetch_misalign_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_o;
    logic [31:0] stall_count_o;
    logic [31:0] w_fetch_count;
    logic [31:0] w_stall_count;
`endif

    logic [31:0] w_pc;
    logic [31:0] w_instr_in;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_pc4;
    logic        w_mis;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign instruction = mem_word(program_counter);
    assign w_instr_in  = mem_word(w_pc);

    instruction_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .program_counter   (program_counter),
        .instruction       (instruction),
        .if_id_valid_o     (if_id_valid_o),
        .if_id_instr_o     (if_id_instr_o),
        .if_id_pc_o        (if_id_pc_o),
        .if_id_pc_plus4_o  (if_id_pc_plus4_o),
        .fetch_misalign_o  (fetch_misalign_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o     (fetch_count_o),
        .stall_count_o     (stall_count_o)
`endif
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (1'b0),
        .redirect_i        (1'b0),
        .redirect_target_i (32'h0),
        .program_counter   (w_pc),
        .instruction       (w_instr_in),
        .if_id_valid_o     (w_valid),
        .if_id_instr_o     (w_instr),
        .if_id_pc_o        (w_if_pc),
        .if_id_pc_plus4_o  (w_if_pc4),
        .fetch_misalign_o  (w_mis)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o     (w_fetch_count),
        .stall_count_o     (w_stall_count)
`endif
    );

    // Behavioural model state, updated once per rising edge from the stage's rules.
    logic [31:0] m_pc, m_instr, m_pcf, m_pc4, m_fcnt, m_scnt;
    logic        m_valid, m_mis;

    task automatic model_edge(input logic st, input logic rd, input logic [31:0] tg, input logic rs);
        if (rs) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_pcf = 0; m_pc4 = 0;
            m_mis = 1'b0; m_fcnt = 0; m_scnt = 0;
        end else begin
            m_mis = rd && (tg % 4 != 0);
            if (rd) begin
                m_pc = tg - (tg % 4);
                m_valid = 1'b0; m_instr = NOP; m_pcf = 0; m_pc4 = 0;
            end else if (st) begin
                if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            end else begin
                m_valid = 1'b1; m_instr = mem_word(m_pc); m_pcf = m_pc; m_pc4 = m_pc + 4;
                m_pc = m_pc + 4;
                if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are examined on the next falling edge.
    task automatic tick(input logic st, input logic rd, input logic [31:0] tg, input logic rs);
        stall_i = st; redirect_i = rd; redirect_target_i = tg; reset = rs;
        @(posedge clk);
        model_edge(st, rd, tg, rs);
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " pc"},    program_counter,   m_pc);
        chk({tag, " valid"}, {31'b0, if_id_valid_o}, {31'b0, m_valid});
        chk({tag, " instr"}, if_id_instr_o,     m_instr);
        chk({tag, " if_pc"}, if_id_pc_o,        m_pcf);
        chk({tag, " pc4"},   if_id_pc_plus4_o,  m_pc4);
        chk({tag, " mis"},   {31'b0, fetch_misalign_o}, {31'b0, m_mis});
`ifdef FETCH_PERF_CNT_EN
        chk({tag, " fcnt"},  fetch_count_o,     m_fcnt);
        chk({tag, " scnt"},  stall_count_o,     m_scnt);
`endif
    endtask

    typedef struct {
        logic        st;
        logic        rd;
        logic        rs;
        logic [31:0] tg;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_pcf;
        logic        e_mis;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h4,   1'b1, 32'h0,   1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h8,   1'b1, 32'h4,   1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h8,   1'b1, 32'h4,   1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h8,   1'b1, 32'h4,   1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h8,   1'b1, 32'h4,   1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'hC,   1'b1, 32'h8,   1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h40,  32'h40,  1'b0, 32'h0,   1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h44,  1'b1, 32'h40,  1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h20,  32'h20,  1'b0, 32'h0,   1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h24,  1'b1, 32'h20,  1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h22,  32'h20,  1'b0, 32'h0,   1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h24,  1'b1, 32'h20,  1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h100, 1'b0, 32'h0,   1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h200, 32'h200, 1'b0, 32'h0,   1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h204, 1'b1, 32'h200, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h204, 1'b1, 32'h200, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h4,   1'b1, 32'h0,   1'b0};

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            tick(tbl[i].st, tbl[i].rd, tbl[i].tg, tbl[i].rs);
            chk($sformatf("vec%0d pc", i),    program_counter, tbl[i].e_pc);
            chk($sformatf("vec%0d valid", i), {31'b0, if_id_valid_o}, {31'b0, tbl[i].e_v});
            chk($sformatf("vec%0d if_pc", i), if_id_pc_o, tbl[i].e_pcf);
            chk($sformatf("vec%0d instr", i), if_id_instr_o,
                tbl[i].e_v ? mem_word(tbl[i].e_pcf) : NOP);
            chk($sformatf("vec%0d pc4", i),   if_id_pc_plus4_o,
                tbl[i].e_v ? tbl[i].e_pcf + 32'd4 : 32'h0);
            chk($sformatf("vec%0d mis", i),   {31'b0, fetch_misalign_o}, {31'b0, tbl[i].e_mis});
            if (i == 0) begin
                chk("wrap rst pc",    w_pc, 32'hFFFF_FFFC);
                chk("wrap rst valid", {31'b0, w_valid}, 32'h0);
            end
            if (i == 1) begin
                chk("wrap pc",    w_pc, 32'h0);
                chk("wrap if_pc", w_if_pc, 32'hFFFF_FFFC);
                chk("wrap pc4",   w_if_pc4, 32'h0);
                chk("wrap instr", w_instr, mem_word(32'hFFFF_FFFC));
                chk("wrap valid", {31'b0, w_valid}, 32'h1);
            end
        end

        // Since the reset in row 17: one advance so far; add 4 advances, 2 stalls, 1 redirect.
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b1, 32'h80, 1'b0);
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        chk_model("perfseq");
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count_o, 32'd5);
        chk("stall_count", stall_count_o, 32'd2);
`endif

        for (int i = 0; i < 400; i++) begin
            logic st, rd, rs;
            logic [31:0] tg;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 6) == 0);
            rs = ($urandom_range(0, 49) == 0);
            tg = $urandom & 32'h0000_FFFF;
            tick(st, rd, tg, rs);
            chk_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
